// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer and its credit counter.
package fetch_seq_pkg;

  localparam int unsigned FETCH_WORD_BYTES = 4;
  localparam int unsigned FETCH_XLEN       = 32;

  typedef enum logic [1:0] {
    RESET       = 2'd0,
    REQ         = 2'd1,
    WAIT_CREDIT = 2'd2,
    DRAIN       = 2'd3
  } type_fetch_seq_state_e;

  typedef struct packed {
    logic                  req;
    logic [FETCH_XLEN-1:0] addr;
  } type_fetch_req_s;

  typedef struct packed {
    logic                  push;
    logic [31:0]           data;
    logic [FETCH_XLEN-1:0] pc;
  } type_fetch_push_s;

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// Fetch sequencer bundle: redirect/pop control, MMU/icache request port and
// prefetch buffer push port. master = sequencer, slave = surrounding core.
interface fetch_seq_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            pop_i;
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_ack_i;
  logic [31:0]     mem_rdata_i;
  logic            buf_push_o;
  logic [31:0]     buf_data_o;
  logic [XLEN-1:0] buf_pc_o;
  logic            buf_flush_o;
  logic [2:0]      occupancy_o;
  logic [31:0]     discard_cnt_o;
  logic [31:0]     starve_cnt_o;

  modport master (
    input  redirect_i, redirect_pc_i, pop_i, mem_ack_i, mem_rdata_i,
    output mem_req_o, mem_addr_o, buf_push_o, buf_data_o, buf_pc_o, buf_flush_o,
    output occupancy_o, discard_cnt_o, starve_cnt_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, pop_i, mem_ack_i, mem_rdata_i,
    input  mem_req_o, mem_addr_o, buf_push_o, buf_data_o, buf_pc_o, buf_flush_o,
    input  occupancy_o, discard_cnt_o, starve_cnt_o
  );
endinterface

// File: rtl/fetch_credit_cnt.sv
// Prefetch buffer occupancy counter: +push, -pop, flush clears. A pop against an
// empty buffer is dropped. Flush wins over both push and pop.
module fetch_credit_cnt
  import fetch_seq_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output logic       pop_accepted_o,
  output logic [2:0] occupancy_o
);

  logic [2:0] occ_q;

  assign pop_accepted_o = pop_i && (occ_q != 3'd0);
  assign occupancy_o    = occ_q;

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= 3'd0;
    end else if (flush_i) begin
      occ_q <= 3'd0;
    end else if (push_i && !pop_accepted_o) begin
      occ_q <= occ_q + 3'd1;
    end else if (!push_i && pop_accepted_o) begin
      occ_q <= occ_q - 3'd1;
    end
  end

  // The outstanding request reserves its slot, so a push never lands on a full buffer.
  occ_in_range_a: assert property (@(posedge clk) disable iff (!rst_n)
    occ_q <= 3'(BUF_DEPTH));
  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !flush_i && !pop_accepted_o && occ_q >= 3'(BUF_DEPTH)));

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns the word-aligned fetch address, issues one outstanding
// request at a time, pushes responses under credit control and drains any
// in-flight response after a redirect.
// Optional feature macro: FETCH_PERF_CNT_EN (discard / starvation counters).
module fetch_seq_ctrl
  import fetch_seq_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     BUF_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h8000_0000)
) (
  input logic              clk,
  input logic              rst_n,
  fetch_seq_ctrl_if.master bus
);

  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(FETCH_WORD_BYTES - 1);
  localparam logic [XLEN-1:0] WORD_STEP = XLEN'(FETCH_WORD_BYTES);

  type_fetch_seq_state_e state_q;
  logic [XLEN-1:0]       addr_q;
  logic [XLEN-1:0]       target_q;
  logic                  req_q;

  logic [2:0]      occupancy;
  logic            pop_accepted;
  logic            push;
  logic            has_room;
  logic [XLEN-1:0] redirect_tgt;

  // Push decode and credit check for the word being acked this cycle.
  always_comb begin
    redirect_tgt = bus.redirect_pc_i & WORD_MASK;
    push         = bus.mem_ack_i && (state_q == REQ) && !bus.redirect_i;
    has_room     = (({1'b0, occupancy} + 4'd1 - {3'b000, pop_accepted}) < 4'(BUF_DEPTH));
  end

  fetch_credit_cnt #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_credit_cnt (
    .clk            (clk),
    .rst_n          (rst_n),
    .push_i         (push),
    .pop_i          (bus.pop_i),
    .flush_i        (bus.redirect_i),
    .pop_accepted_o (pop_accepted),
    .occupancy_o    (occupancy)
  );

  // Fetch FSM with fetch address, drain target and registered request strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RESET;
      addr_q   <= RESET_PC;
      target_q <= RESET_PC;
      req_q    <= 1'b0;
    end else begin
      unique case (state_q)
        RESET, WAIT_CREDIT: begin
          if (bus.redirect_i) begin
            addr_q  <= redirect_tgt;
            state_q <= REQ;
            req_q   <= 1'b1;
          end else if (state_q == RESET || pop_accepted) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (bus.redirect_i && !bus.mem_ack_i) begin
            // Request cannot be retracted: keep the old address until its ack.
            target_q <= redirect_tgt;
            state_q  <= DRAIN;
          end else if (bus.redirect_i) begin
            addr_q <= redirect_tgt;
          end else if (bus.mem_ack_i) begin
            addr_q <= addr_q + WORD_STEP;
            if (!has_room) begin
              state_q <= WAIT_CREDIT;
              req_q   <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (bus.mem_ack_i) begin
            addr_q  <= bus.redirect_i ? redirect_tgt : target_q;
            state_q <= REQ;
          end else if (bus.redirect_i) begin
            target_q <= redirect_tgt;
          end
        end
        default: begin
          state_q <= RESET;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  req_held_a: assert property (@(posedge clk) disable iff (!rst_n)
    req_q && !bus.mem_ack_i |=> req_q && $stable(addr_q));

  assign bus.mem_req_o   = req_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.buf_push_o  = push;
  assign bus.buf_data_o  = bus.mem_rdata_i;
  assign bus.buf_pc_o    = addr_q;
  assign bus.buf_flush_o = bus.redirect_i;
  assign bus.occupancy_o = occupancy;

`ifdef FETCH_PERF_CNT_EN
  logic        discard;
  logic [31:0] discard_cnt_q;
  logic [31:0] starve_cnt_q;

  assign discard = bus.mem_ack_i &&
                   ((state_q == REQ && bus.redirect_i) || state_q == DRAIN);

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard_cnt_q <= 32'd0;
      starve_cnt_q  <= 32'd0;
    end else begin
      if (discard && discard_cnt_q != '1) begin
        discard_cnt_q <= discard_cnt_q + 32'd1;
      end
      if (occupancy == 3'd0 && !push && starve_cnt_q != '1) begin
        starve_cnt_q <= starve_cnt_q + 32'd1;
      end
    end
  end

  assign bus.discard_cnt_o = discard_cnt_q;
  assign bus.starve_cnt_o  = starve_cnt_q;
`else
  assign bus.discard_cnt_o = 32'd0;
  assign bus.starve_cnt_o  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Testbench for fetch_seq_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level model of the fetch/credit rules.
module tb_fetch_seq_ctrl;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  fetch_seq_ctrl_if #(.XLEN(32)) bus ();

  fetch_seq_ctrl #(
    .XLEN      (32),
    .BUF_DEPTH (DEPTH),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic set_in(input logic red, input logic [31:0] rpc, input logic pop,
                        input logic ack, input logic [31:0] rd);
    bus.redirect_i    = red;
    bus.redirect_pc_i = rpc;
    bus.pop_i         = pop;
    bus.mem_ack_i     = ack;
    bus.mem_rdata_i   = rd;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    n_checks++; if (bus.mem_req_o !== 1'b0)
      $display("FAIL reset_req got %b want 0", bus.mem_req_o); else n_pass++;
    n_checks++; if (bus.mem_addr_o !== RST_PC)
      $display("FAIL reset_addr got %h want %h", bus.mem_addr_o, RST_PC); else n_pass++;
    n_checks++; if (bus.buf_push_o !== 1'b0 || bus.buf_flush_o !== 1'b0)
      $display("FAIL reset_push_flush got %b%b want 00", bus.buf_push_o, bus.buf_flush_o);
    else n_pass++;
    n_checks++; if (bus.occupancy_o !== 3'd0)
      $display("FAIL reset_occ got %0d want 0", bus.occupancy_o); else n_pass++;
    n_checks++; if (bus.discard_cnt_o !== 32'd0 || bus.starve_cnt_o !== 32'd0)
      $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.discard_cnt_o, bus.starve_cnt_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.mem_req_o !== 1'b0)
      $display("FAIL reset_state_req got %b want 0", bus.mem_req_o); else n_pass++;
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== RST_PC)
      $display("FAIL first_req got %b@%h want 1@%h", bus.mem_req_o, bus.mem_addr_o, RST_PC);
    else n_pass++;
  endtask

  task automatic test_fill();
    reset_dut();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.mem_req_o !== 1'b1 || bus.buf_push_o !== 1'b0)
      $display("FAIL fill_req0 got req=%b push=%b want 1/0", bus.mem_req_o, bus.buf_push_o);
    else n_pass++;
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'hA5A5_0001);
    n_checks++; if (bus.buf_push_o !== 1'b1 || bus.buf_pc_o !== 32'h8000_0000 ||
                    bus.buf_data_o !== 32'hA5A5_0001)
      $display("FAIL fill_push0 got %b pc=%h d=%h want 1 pc=80000000 d=a5a50001",
               bus.buf_push_o, bus.buf_pc_o, bus.buf_data_o);
    else n_pass++;
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h8000_0004 ||
                    bus.occupancy_o !== 3'd1)
      $display("FAIL fill_req1 got %b@%h occ=%0d want 1@80000004 occ=1",
               bus.mem_req_o, bus.mem_addr_o, bus.occupancy_o);
    else n_pass++;
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'hA5A5_0002);
    n_checks++; if (bus.buf_push_o !== 1'b1 || bus.buf_pc_o !== 32'h8000_0004)
      $display("FAIL fill_push1 got %b pc=%h want 1 pc=80000004", bus.buf_push_o, bus.buf_pc_o);
    else n_pass++;
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.mem_req_o !== 1'b0 || bus.occupancy_o !== 3'd2)
      $display("FAIL fill_wait got req=%b occ=%0d want 0/2", bus.mem_req_o, bus.occupancy_o);
    else n_pass++;
    n_checks++; if (bus.starve_cnt_o !== (PERF ? 32'd2 : 32'd0))
      $display("FAIL fill_starve got %0d want %0d", bus.starve_cnt_o, PERF ? 2 : 0);
    else n_pass++;
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    n_checks++; if (bus.mem_req_o !== 1'b0 || bus.buf_push_o !== 1'b0)
      $display("FAIL fill_hold got req=%b push=%b want 0/0", bus.mem_req_o, bus.buf_push_o);
    else n_pass++;
    tick();
  endtask

  // Continues from the full buffer left by test_fill.
  task automatic test_pop_refill();
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    n_checks++; if (bus.mem_req_o !== 1'b0)
      $display("FAIL pop_same_cycle got req=%b want 0", bus.mem_req_o); else n_pass++;
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h8000_0008 ||
                    bus.occupancy_o !== 3'd1)
      $display("FAIL pop_refill got %b@%h occ=%0d want 1@80000008 occ=1",
               bus.mem_req_o, bus.mem_addr_o, bus.occupancy_o);
    else n_pass++;
    tick();
    set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h1234_5678);
    n_checks++; if (bus.buf_push_o !== 1'b1 || bus.buf_pc_o !== 32'h8000_0008)
      $display("FAIL pushpop_push got %b pc=%h want 1 pc=80000008", bus.buf_push_o, bus.buf_pc_o);
    else n_pass++;
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.occupancy_o !== 3'd1 || bus.mem_req_o !== 1'b1 ||
                    bus.mem_addr_o !== 32'h8000_000C)
      $display("FAIL pushpop_steady got occ=%0d %b@%h want occ=1 1@8000000c",
               bus.occupancy_o, bus.mem_req_o, bus.mem_addr_o);
    else n_pass++;
  endtask

  task automatic test_redirect_drain();
    reset_dut();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0011);
    tick();
    set_in(1'b1, 32'h8000_0102, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.buf_flush_o !== 1'b1 || bus.buf_push_o !== 1'b0)
      $display("FAIL drain_flush got flush=%b push=%b want 1/0", bus.buf_flush_o, bus.buf_push_o);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      n_checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h8000_0004 ||
                      bus.buf_flush_o !== 1'b0 || bus.occupancy_o !== 3'd0)
        $display("FAIL drain_hold%0d got %b@%h flush=%b occ=%0d want 1@80000004 0 0",
                 i, bus.mem_req_o, bus.mem_addr_o, bus.buf_flush_o, bus.occupancy_o);
      else n_pass++;
    end
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    n_checks++; if (bus.buf_push_o !== 1'b0)
      $display("FAIL drain_discard got push=%b want 0", bus.buf_push_o); else n_pass++;
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h8000_0100)
      $display("FAIL drain_resume got %b@%h want 1@80000100", bus.mem_req_o, bus.mem_addr_o);
    else n_pass++;
    n_checks++; if (bus.discard_cnt_o !== (PERF ? 32'd1 : 32'd0))
      $display("FAIL drain_discard_cnt got %0d want %0d", bus.discard_cnt_o, PERF ? 1 : 0);
    else n_pass++;
  endtask

  task automatic test_redirect_with_ack();
    reset_dut();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0022);
    tick();
    set_in(1'b1, 32'h8000_0040, 1'b1, 1'b1, 32'h0000_0033);
    n_checks++; if (bus.buf_push_o !== 1'b0 || bus.buf_flush_o !== 1'b1)
      $display("FAIL redack_push got push=%b flush=%b want 0/1", bus.buf_push_o, bus.buf_flush_o);
    else n_pass++;
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.occupancy_o !== 3'd0 || bus.mem_req_o !== 1'b1 ||
                    bus.mem_addr_o !== 32'h8000_0040)
      $display("FAIL redack_next got occ=%0d %b@%h want 0 1@80000040",
               bus.occupancy_o, bus.mem_req_o, bus.mem_addr_o);
    else n_pass++;
    n_checks++; if (bus.discard_cnt_o !== (PERF ? 32'd1 : 32'd0))
      $display("FAIL redack_discard_cnt got %0d want %0d", bus.discard_cnt_o, PERF ? 1 : 0);
    else n_pass++;
  endtask

  task automatic test_double_redirect();
    reset_dut();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== RST_PC)
      $display("FAIL dbl_hold got %b@%h want 1@%h", bus.mem_req_o, bus.mem_addr_o, RST_PC);
    else n_pass++;
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0044);
    n_checks++; if (bus.buf_push_o !== 1'b0)
      $display("FAIL dbl_discard got push=%b want 0", bus.buf_push_o); else n_pass++;
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_0200)
      $display("FAIL dbl_resume got %b@%h want 1@00000200", bus.mem_req_o, bus.mem_addr_o);
    else n_pass++;
    n_checks++; if (bus.discard_cnt_o !== (PERF ? 32'd1 : 32'd0))
      $display("FAIL dbl_discard_cnt got %0d want %0d", bus.discard_cnt_o, PERF ? 1 : 0);
    else n_pass++;
  endtask

  task automatic test_wrap_and_reset();
    reset_dut();
    set_in(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0055);
    n_checks++; if (bus.mem_addr_o !== 32'hFFFF_FFFC || bus.buf_push_o !== 1'b1 ||
                    bus.buf_pc_o !== 32'hFFFF_FFFC)
      $display("FAIL wrap_top got addr=%h push=%b pc=%h want fffffffc 1 fffffffc",
               bus.mem_addr_o, bus.buf_push_o, bus.buf_pc_o);
    else n_pass++;
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_0000)
      $display("FAIL wrap_next got %b@%h want 1@00000000", bus.mem_req_o, bus.mem_addr_o);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== RST_PC ||
                    bus.occupancy_o !== 3'd0 || bus.buf_push_o !== 1'b0)
      $display("FAIL async_reset got %b@%h occ=%0d push=%b want 0@%h 0 0",
               bus.mem_req_o, bus.mem_addr_o, bus.occupancy_o, bus.buf_push_o, RST_PC);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int          m_occ;
    bit          m_out;
    bit          m_doomed;
    logic [31:0] m_addr;
    logic [31:0] m_target;
    logic [31:0] m_disc;
    logic [31:0] m_starve;
    logic        red, pop, ack, acc, e_push, pop_ok;
    logic [31:0] rpc, rd;

    reset_dut();
    m_occ    = 0;
    m_out    = 1'b0;
    m_doomed = 1'b0;
    m_addr   = RST_PC;
    m_target = RST_PC;
    m_disc   = 32'd0;
    m_starve = 32'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      red = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      pop = 1'($urandom_range(0, 1));
      ack = 1'($urandom_range(0, 1));
      rd  = $urandom;
      set_in(red, rpc, pop, ack, rd);

      acc    = m_out && ack;
      e_push = acc && !m_doomed && !red;
      n_checks++; if (bus.mem_req_o !== m_out || bus.mem_addr_o !== m_addr)
        $display("FAIL rnd_req c%0d got %b@%h want %b@%h",
                 cyc, bus.mem_req_o, bus.mem_addr_o, m_out, m_addr);
      else n_pass++;
      n_checks++; if (bus.buf_push_o !== e_push || bus.buf_flush_o !== red)
        $display("FAIL rnd_push c%0d got push=%b flush=%b want %b/%b",
                 cyc, bus.buf_push_o, bus.buf_flush_o, e_push, red);
      else n_pass++;
      if (e_push) begin
        n_checks++; if (bus.buf_pc_o !== m_addr || bus.buf_data_o !== rd)
          $display("FAIL rnd_pushdata c%0d got pc=%h d=%h want pc=%h d=%h",
                   cyc, bus.buf_pc_o, bus.buf_data_o, m_addr, rd);
        else n_pass++;
      end
      n_checks++; if (bus.occupancy_o !== 3'(m_occ))
        $display("FAIL rnd_occ c%0d got %0d want %0d", cyc, bus.occupancy_o, m_occ);
      else n_pass++;
      n_checks++; if (bus.discard_cnt_o !== (PERF ? m_disc : 32'd0) ||
                      bus.starve_cnt_o !== (PERF ? m_starve : 32'd0))
        $display("FAIL rnd_cnt c%0d got %0d/%0d want %0d/%0d", cyc, bus.discard_cnt_o,
                 bus.starve_cnt_o, PERF ? m_disc : 0, PERF ? m_starve : 0);
      else n_pass++;

      // Reference: one request in flight, each held word costs a credit,
      // a redirect empties the buffer and dooms any request still in flight.
      pop_ok = pop && (m_occ > 0);
      if (m_occ == 0 && !e_push && m_starve != '1) m_starve = m_starve + 1;
      if (acc && (m_doomed || red) && m_disc != '1) m_disc = m_disc + 1;
      if (red) begin
        m_occ = 0;
        if (m_out && !acc) begin
          m_doomed = 1'b1;
          m_target = rpc & ~32'h3;
        end else begin
          m_addr   = rpc & ~32'h3;
          m_out    = 1'b1;
          m_doomed = 1'b0;
        end
      end else begin
        m_occ = m_occ + (e_push ? 1 : 0) - (pop_ok ? 1 : 0);
        if (acc) begin
          m_addr   = m_doomed ? m_target : m_addr + 32'd4;
          m_doomed = 1'b0;
          m_out    = (m_occ < DEPTH);
        end else if (!m_out) begin
          m_out = (m_occ < DEPTH);
        end
      end
      tick();
    end
  endtask

  initial begin
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.pop_i         = 1'b0;
    bus.mem_ack_i     = 1'b0;
    bus.mem_rdata_i   = 32'h0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_pop_refill();
    test_redirect_drain();
    test_redirect_with_ack();
    test_double_redirect();
    test_wrap_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
